// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory controller driving a req/gnt/rvalid bus with byte enables and load extension
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic [DATA_WIDTH-1:0]   mem_data_i,
    input  logic                    mem_we_i,
    input  logic [3:0]              mem_op_i,
    input  logic [4:0]              reg_waddr_i,
    input  logic                    reg_we_i,
    input  logic [DATA_WIDTH-1:0]   reg_wdata_i,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [ADDR_WIDTH-1:0]   bus_addr_o,
    output logic [DATA_WIDTH/8-1:0] bus_be_o,
    output logic [DATA_WIDTH-1:0]   bus_wdata_o,
    input  logic                    bus_gnt_i,
    input  logic                    bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
    output logic                    stall_req_o,
    output logic [4:0]              reg_waddr_o,
    output logic                    reg_we_o,
    output logic [DATA_WIDTH-1:0]   reg_wdata_o,
    output logic                    misalign_o,
    output logic                    bus_err_o
);
    localparam int BW = DATA_WIDTH / 8;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
    state_t state, nxt;
    logic [7:0] cnt;
    logic [DATA_WIDTH-1:0] rdata_q, lane, ext;
    logic is_b, is_h, is_w, ld, sto, acc, mis, go, busy, done_ok, to, capture;
    // an op whose store/load kind disagrees with mem_we_i is treated as NOP
    assign is_b = mem_op_i inside {4'd1, 4'd4, 4'd6};
    assign is_h = mem_op_i inside {4'd2, 4'd5, 4'd7};
    assign is_w = mem_op_i inside {4'd3, 4'd8};
    assign ld = (mem_op_i inside {[4'd1:4'd5]}) & ~mem_we_i;
    assign sto = (mem_op_i inside {[4'd6:4'd8]}) & mem_we_i;
    assign acc = ld | sto;
    assign mis = acc & ((is_h & mem_addr_i[0]) | (is_w & |mem_addr_i[1:0]));
    assign go = acc & ~mis;
    assign busy = (state == S_REQ) | (state == S_WAIT);
    assign done_ok = (state == S_REQ & bus_gnt_i & (sto | bus_rvalid_i)) | (state == S_WAIT & bus_rvalid_i);
    assign to = busy & (cnt == 8'(TIMEOUT - 1));
    assign capture = ld & bus_rvalid_i & ((state == S_REQ & bus_gnt_i) | state == S_WAIT);
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: nxt = go ? S_REQ : S_IDLE;
            S_REQ:  nxt = (done_ok | to) ? S_DONE : bus_gnt_i ? S_WAIT : S_REQ;
            S_WAIT: nxt = (done_ok | to) ? S_DONE : S_WAIT;
            default: nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_err_o   <= 1'b0;
            bus_be_o    <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            rdata_q     <= '0;
            cnt         <= '0;
        end else begin
            bus_req_o <= nxt == S_REQ;
            bus_err_o <= to & ~done_ok;
            if (state == S_IDLE && go) begin
                bus_we_o    <= sto;
                bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                bus_be_o    <= is_b ? BW'(1) << mem_addr_i[1:0] : is_h ? BW'(3) << mem_addr_i[1:0] : '1;
                bus_wdata_o <= is_b ? {(DATA_WIDTH/8){mem_data_i[7:0]}} : is_h ? {(DATA_WIDTH/16){mem_data_i[15:0]}} : mem_data_i;
                cnt         <= '0;
            end else if (busy) cnt <= cnt + 8'd1;
            if (capture) rdata_q <= bus_rdata_i;
        end
    end
    assign lane = rdata_q >> {mem_addr_i[1:0], 3'b000};
    assign ext = mem_op_i == 4'd1 ? {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]} :
                 mem_op_i == 4'd2 ? {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]} :
                 mem_op_i == 4'd4 ? {{(DATA_WIDTH-8){1'b0}}, lane[7:0]} :
                 mem_op_i == 4'd5 ? {{(DATA_WIDTH-16){1'b0}}, lane[15:0]} : lane;
    // stall is gated by reset so an in-flight access releases upstream at once
    assign stall_req_o = rst_i & ((state == S_IDLE & go) | busy);
    assign misalign_o = mis;
    assign reg_waddr_o = reg_waddr_i;
    assign reg_we_o = state == S_IDLE ? reg_we_i & ~acc : state == S_DONE ? reg_we_i & ~bus_err_o : 1'b0;
    assign reg_wdata_o = (state == S_DONE & ld & ~bus_err_o) ? ext : reg_wdata_i;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;
    logic clk_i = 1'b0, rst_i = 1'b0;
    logic [31:0] mem_addr_i = '0, mem_data_i = '0, reg_wdata_i = '0, bus_rdata_i = '0;
    logic mem_we_i = 1'b0, reg_we_i = 1'b0, bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0;
    logic [3:0] mem_op_i = '0;
    logic [4:0] reg_waddr_i = '0;
    logic bus_req_o, bus_we_o, stall_req_o, reg_we_o, misalign_o, bus_err_o;
    logic [31:0] bus_addr_o, bus_wdata_o, reg_wdata_o;
    logic [3:0] bus_be_o;
    logic [4:0] reg_waddr_o;
    int total = 0, bad = 0;
    typedef struct {logic we; logic [31:0] wd; logic err; int cyc;} exp_t;
    exp_t sb[$];
    mem_access_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_we_i(mem_we_i), .mem_op_i(mem_op_i), .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i),
        .reg_wdata_i(reg_wdata_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .stall_req_o(stall_req_o), .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o),
        .reg_wdata_o(reg_wdata_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask
    task automatic nop;
        mem_op_i = 4'd0;
        mem_we_i = 1'b0;
        bus_gnt_i = 1'b0;
        bus_rvalid_i = 1'b0;
    endtask
    task automatic access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d, input logic rwe,
                          input int gd, input int rd, input logic [31:0] rdat, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic ewe, input logic [31:0] ereg,
                          input logic eerr, input int ecyc);
        int cyc = 0;
        exp_t e;
        mem_op_i = op;
        mem_addr_i = a;
        mem_data_i = d;
        mem_we_i = op >= 4'd6;
        reg_we_i = rwe;
        reg_waddr_i = 5'(op) + 5'd3;
        reg_wdata_i = 32'hA0A0_0000;
        #1;
        chk("idle_stall", stall_req_o, 1);
        chk("idle_misalign", misalign_o, 0);
        chk("idle_reg_we", reg_we_o, 0);
        sb.push_back('{ewe, ereg, eerr, ecyc});
        forever begin
            tick;
            if (!stall_req_o) break;
            if (cyc == 0) begin
                chk("bus_addr", bus_addr_o, a & 32'hFFFF_FFFC);
                chk("bus_be", bus_be_o, ebe);
                chk("bus_we", bus_we_o, op >= 4'd6);
                if (op >= 4'd6) chk("bus_wdata", bus_wdata_o, ewd);
            end
            chk("bus_req", bus_req_o, gd < 0 || cyc <= gd);
            chk("busy_reg_we", reg_we_o, 0);
            bus_gnt_i = cyc == gd;
            bus_rvalid_i = op <= 4'd5 && gd >= 0 && cyc == gd + rd;
            bus_rdata_i = bus_rvalid_i ? rdat : 32'h0BAD_0BAD;
            cyc++;
            if (cyc > 400) begin
                total++;
                bad++;
                $error("FAIL budget: got %0d cycles want %0d", cyc, ecyc);
                break;
            end
        end
        e = sb.pop_front();
        chk("cycles", cyc, e.cyc);
        chk("done_reg_we", reg_we_o, e.we);
        chk("done_reg_wdata", reg_wdata_o, e.wd);
        chk("done_err", bus_err_o, e.err);
        chk("done_waddr", reg_waddr_o, 5'(op) + 5'd3);
        nop;
    endtask
    initial begin
        tick;
        tick;
        chk("rst_req", bus_req_o, 0);
        chk("rst_we", bus_we_o, 0);
        chk("rst_be", bus_be_o, 0);
        chk("rst_addr", bus_addr_o, 0);
        chk("rst_wdata", bus_wdata_o, 0);
        chk("rst_err", bus_err_o, 0);
        chk("rst_stall", stall_req_o, 0);
        rst_i = 1'b1;
        tick;
        access(4'd8, 32'h100, 32'hDEAD_BEEF, 1'b0, 0, 0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'hA0A0_0000, 1'b0, 1);
        tick;
        access(4'd1, 32'h103, 32'h0, 1'b1, 0, 2, 32'h80FF_FFFF, 4'h8, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 3);
        tick;
        access(4'd5, 32'h202, 32'h0, 1'b1, 0, 0, 32'h8001_0000, 4'hC, 32'h0, 1'b1, 32'h0000_8001, 1'b0, 1);
        tick;
        access(4'd6, 32'h102, 32'h0000_00A5, 1'b0, 2, 0, 32'h0, 4'h4, 32'hA5A5_A5A5, 1'b0, 32'hA0A0_0000, 1'b0, 3);
        tick;
        access(4'd7, 32'h202, 32'h0000_1234, 1'b0, 1, 0, 32'h0, 4'hC, 32'h1234_1234, 1'b0, 32'hA0A0_0000, 1'b0, 2);
        tick;
        access(4'd2, 32'h100, 32'h0, 1'b1, 1, 1, 32'h1234_F00D, 4'h3, 32'h0, 1'b1, 32'hFFFF_F00D, 1'b0, 3);
        tick;
        access(4'd4, 32'h101, 32'h0, 1'b1, 0, 1, 32'h0000_9A00, 4'h2, 32'h0, 1'b1, 32'h0000_009A, 1'b0, 2);
        tick;
        access(4'd3, 32'h104, 32'h0, 1'b1, 3, 0, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 4);
        tick;
        mem_op_i = 4'd3;
        mem_addr_i = 32'h101;
        reg_we_i = 1'b1;
        #1;
        chk("mis_flag", misalign_o, 1);
        chk("mis_stall", stall_req_o, 0);
        chk("mis_reg_we", reg_we_o, 0);
        tick;
        chk("mis_req", bus_req_o, 0);
        chk("mis_stall2", stall_req_o, 0);
        nop;
        tick;
        access(4'd3, 32'h300, 32'h0, 1'b1, -1, 0, 32'h0, 4'hF, 32'h0, 1'b0, 32'hA0A0_0000, 1'b1, 255);
        reg_we_i = 1'b1;
        reg_waddr_i = 5'd7;
        reg_wdata_i = 32'h1234_5678;
        tick;
        chk("err_pulse", bus_err_o, 0);
        chk("nop_stall", stall_req_o, 0);
        chk("nop_we", reg_we_o, 1);
        chk("nop_wdata", reg_wdata_o, 32'h1234_5678);
        chk("nop_waddr", reg_waddr_o, 5'd7);
        mem_op_i = 4'd12;
        #1;
        chk("badop_stall", stall_req_o, 0);
        chk("badop_we", reg_we_o, 1);
        tick;
        chk("badop_req", bus_req_o, 0);
        mem_op_i = 4'd3;
        mem_addr_i = 32'h400;
        reg_we_i = 1'b1;
        tick;
        bus_gnt_i = 1'b1;
        tick;
        bus_gnt_i = 1'b0;
        #1;
        chk("wait_stall", stall_req_o, 1);
        chk("wait_req", bus_req_o, 0);
        rst_i = 1'b0;
        #1;
        chk("rstw_stall", stall_req_o, 0);
        chk("rstw_req", bus_req_o, 0);
        tick;
        rst_i = 1'b1;
        tick;
        chk("rel_req", bus_req_o, 1);
        rst_i = 1'b0;
        #1;
        chk("rstr_req", bus_req_o, 0);
        chk("rstr_stall", stall_req_o, 0);
        nop;
        tick;
        rst_i = 1'b1;
        tick;
        chk("post_stall", stall_req_o, 0);
        chk("post_req", bus_req_o, 0);
        access(4'd8, 32'h108, 32'h0BAD_F00D, 1'b0, 0, 0, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, 32'hA0A0_0000, 1'b0, 1);
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
